div_unit: RTL
=============

Name: div_unit

Overview:
- Sequential signed 32-bit divider for the multicycle MIPS datapath, implementing DIV.
- Operands come from the A register (dividend) and B register (divisor).
- Quotient goes to the LOdiv holding register and remainder to the HIdiv holding register.
- Raises the div0 exception flag to the control unit on divide by zero.
- Uses a start/done handshake with the control FSM and computes one quotient bit per cycle (restoring algorithm on magnitudes).

Parameters:
- WIDTH, 32, operand/result width; the bench and datapath use 32 only.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a division; sampled only in IDLE.
- a  in  WIDTH  dividend, two's complement.
- b  in  WIDTH  divisor, two's complement.
- busy  out  1  high from the cycle after start is accepted until done or div0.
- done  out  1  one-cycle pulse; hi and lo are valid in the same cycle.
- div0  out  1  one-cycle pulse: divisor was zero.
- hi  out  WIDTH  remainder.
- lo  out  WIDTH  quotient.

Behaviour:
- Clock and reset: single clock; reset is asynchronous and active-high. All state is cleared immediately on reset assertion.
- Reset values: state=IDLE, busy=0, done=0, div0=0, hi=0, lo=0, counter=0, internal registers=0.
- Reset mid-operation aborts the division. No done or div0 is produced for the aborted operation.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 and b!=0: latch |a|, |b|, sign_q = a[31]^b[31], sign_r = a[31]. Clear the partial remainder, load the counter with WIDTH, go to CALC.
  - start=1 and b==0: go to IDLE, pulse div0 for one cycle. hi and lo are unchanged. busy never rises.
  - start=0: stay in IDLE.
- CALC (one step per cycle):
  - Shift {rem, quo} left by 1.
  - trial = rem_shifted - |b| at WIDTH+1 bits.
  - If trial is non-negative: rem = trial, set quo LSB = 1. Otherwise keep rem and set quo LSB = 0.
  - Decrement the counter. When the counter reaches 0 after a step, go to FIX.
  - Exactly WIDTH CALC cycles.
- FIX:
  - lo = sign_q ? -quo : quo.
  - hi = sign_r ? -rem : rem.
  - Go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, then go to IDLE.
- Latency: start accepted at edge N; done is high in the cycle after edge N+WIDTH+2, i.e. 34 cycles after the start edge for WIDTH=32.
- Output hold: hi and lo hold their value until the next FIX. They are never modified in IDLE, CALC or on div0.
- Semantics: quotient truncates toward zero; the remainder takes the dividend's sign (MIPS DIV).
- Overflow: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 with no exception. The magnitude path handles this naturally; no special case.
- Magnitudes are treated as unsigned WIDTH bits, so |0x80000000| = 0x80000000 is correct.
- start while busy (CALC, FIX, DONE) is ignored; it is not queued.
- a and b are sampled only on the accepting edge; later changes have no effect.

Optional Feature:
- Macro: DIV_UNSIGNED_EN.
- When defined:
  - Adds input port is_unsigned (1 bit), sampled with start.
  - When is_unsigned=1, operands are used as-is with sign_q = sign_r = 0, implementing DIVU.
  - Example: 0xFFFFFFFF / 2 gives lo=0x7FFFFFFF, hi=1.
  - Divide by zero still pulses div0.
- When undefined: the port is absent and all divisions are signed.

Decomposition:
- Package div_pkg holds:
  - state enum type div_state_t {IDLE, CALC, FIX, DONE}.
  - localparams DIV_WIDTH=32 and DIV_LATENCY=34.
- One natural sub-module, div_step: purely combinational. Takes rem, quo and divisor magnitude; returns the next rem and quo. It is instantiated once and used in the CALC state.
- The top module holds the FSM, counter, sign handling and output registers.

Test Plan:
- a=7, b=2, start one cycle → after 34 cycles: done=1, lo=0x00000003, hi=0x00000001; busy low after done.
- a=-7 (0xFFFFFFF9), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- a=7, b=-2 → lo=0xFFFFFFFD, hi=0x00000001.
- a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0, div0=0.
- Preload hi/lo via 100/7 (lo=14, hi=2), then a=5, b=0 → div0 pulses one cycle after start; done never asserts; hi=2, lo=14 unchanged.
- Start 100/7, reassert start with a=1, b=1 at cycle 10 → that start is ignored; result lo=14, hi=2.
- Start 100/7, reset at cycle 15, release, then start 9/3 → lo=3, hi=0; exactly one done pulse.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential signed divider.
package div_pkg;

    localparam int unsigned DIV_WIDTH   = 32;
    localparam int unsigned DIV_CNT_W   = 6;
    localparam int unsigned DIV_LATENCY = 34;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step on magnitudes: shift {rem, quo} left, subtract the divisor if it fits.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_c_o,
    output logic [WIDTH-1:0] quo_c_o
);

    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] trial;

    // rem < dvs always holds, so rem_sh fits WIDTH+1 bits and the result fits WIDTH bits
    always_comb begin
        rem_sh = {rem_i, quo_i[WIDTH-1]};
        trial  = rem_sh - {1'b0, dvs_i};
        if (!trial[WIDTH]) begin
            rem_c_o = trial[WIDTH-1:0];
            quo_c_o = {quo_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_c_o = rem_sh[WIDTH-1:0];
            quo_c_o = {quo_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Sequential signed divider (MIPS DIV): quotient to lo, remainder to hi, one bit per cycle.
// Defining DIV_UNSIGNED_EN adds an is_unsigned input selecting DIVU behaviour.
module div_unit
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH,
    parameter int unsigned CNT_W = DIV_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
`ifdef DIV_UNSIGNED_EN
    input  logic             is_unsigned,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             sgn_quo_q, sgn_quo_d;
    logic             sgn_rem_q, sgn_rem_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             div0_q, div0_d;

    logic             signed_op;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;

`ifdef DIV_UNSIGNED_EN
    assign signed_op = ~is_unsigned;
`else
    assign signed_op = 1'b1;
`endif

    // Magnitudes are unsigned WIDTH bits, so the most negative value maps onto itself correctly
    assign a_neg = signed_op & a[WIDTH-1];
    assign b_neg = signed_op & b[WIDTH-1];
    assign a_mag = a_neg ? (~a + WIDTH'(1)) : a;
    assign b_mag = b_neg ? (~b + WIDTH'(1)) : b;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i   (rem_q),
        .quo_i   (quo_q),
        .dvs_i   (dvs_q),
        .rem_c_o (step_rem),
        .quo_c_o (step_quo)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            sgn_quo_q <= 1'b0;
            sgn_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            div0_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            sgn_quo_q <= sgn_quo_d;
            sgn_rem_q <= sgn_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            div0_q    <= div0_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        sgn_quo_d = sgn_quo_q;
        sgn_rem_d = sgn_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        div0_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (b == '0) begin
                        div0_d = 1'b1;
                    end else begin
                        rem_d     = '0;
                        quo_d     = a_mag;
                        dvs_d     = b_mag;
                        sgn_quo_d = a_neg ^ b_neg;
                        sgn_rem_d = a_neg;
                        cnt_d     = CNT_W'(WIDTH);
                        state_d   = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                lo_d    = sgn_quo_q ? (~quo_q + WIDTH'(1)) : quo_q;
                hi_d    = sgn_rem_q ? (~rem_q + WIDTH'(1)) : rem_q;
                state_d = DONE;
            end
            DONE: begin
                // done is registered, so it rises together with busy falling on the return to IDLE
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign busy = busy_q;
    assign done = done_q;
    assign div0 = div0_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
